// File: rtl/trace_dump_pkg.sv
// Shared types and constants for the trace buffer dump sequencer.
package trace_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNAP,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

  localparam logic [7:0] STATUS_OK         = 8'd0;
  localparam logic [7:0] STATUS_BRESP_ERR  = 8'd1;
  localparam logic [7:0] STATUS_MISALIGNED = 8'd2;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;

  localparam int unsigned PAGE_BYTES = 4096;

  function automatic logic resp_ok(input logic [1:0] resp);
    return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
  endfunction

endpackage

// File: rtl/trace_burst_plan.sv
// Burst length: min(remaining entries, MaxBurst, 8-byte beats left in the 4 KB page).
module trace_burst_plan
  import trace_dump_pkg::*;
#(
  parameter int unsigned CountWidth = 16,
  parameter int unsigned MaxBurst   = 16
) (
  input  logic [CountWidth-1:0] remaining,
  input  logic [11:0]           page_off,
  output logic [8:0]            beats
);

  localparam int unsigned CalcWidth = (CountWidth > 10) ? CountWidth : 10;

  logic [9:0]           room_beats;
  logic [CalcWidth-1:0] pick;

  always_comb begin
    room_beats = 10'((13'(PAGE_BYTES) - {1'b0, page_off}) >> 3);
    pick = CalcWidth'(MaxBurst);
    if (CalcWidth'(remaining) < pick) pick = CalcWidth'(remaining);
    if (CalcWidth'(room_beats) < pick) pick = CalcWidth'(room_beats);
    beats = 9'(pick);
  end

endmodule

// File: rtl/trace_dump_ctrl.sv
// Drains the trace buffer to host memory over AXI4 write bursts on ap_start.
module trace_dump_ctrl
  import trace_dump_pkg::*;
#(
  parameter int unsigned AddrWidth  = 64,
  parameter int unsigned MaxBurst   = 16,
  parameter int unsigned CountWidth = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  input  logic [63:0]           trace_dump,
  output logic [31:0]           tracer_return_code,
  input  logic [CountWidth-1:0] buf_count,
  input  logic [63:0]           buf_data,
  output logic                  buf_pop,
  output logic [AddrWidth-1:0]  awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [63:0]           wdata,
  output logic [7:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  state_t                state, state_next;
  logic [CountWidth-1:0] rem, rem_next;
  logic [AddrWidth-1:0]  addr, addr_next;
  logic [23:0]           written, written_next;
  logic [8:0]            beats, plan_beats, beat_cnt;
  logic [7:0]            done_status;

  // Planned from the next-cycle pointer so awaddr/awlen are registered on AW entry.
  trace_burst_plan #(
    .CountWidth(CountWidth),
    .MaxBurst  (MaxBurst)
  ) u_plan (
    .remaining(rem_next),
    .page_off (addr_next[11:0]),
    .beats    (plan_beats)
  );

  always_comb begin
    state_next   = state;
    rem_next     = rem;
    addr_next    = addr;
    written_next = written;
    done_status  = STATUS_OK;
    unique case (state)
      ST_IDLE: if (ap_start) state_next = ST_SNAP;
      ST_SNAP: begin
        rem_next     = buf_count;
        addr_next    = AddrWidth'(trace_dump);
        written_next = '0;
        if (trace_dump[2:0] != 3'd0) begin
          done_status = STATUS_MISALIGNED;
          state_next  = ST_DONE;
        end else if (buf_count == '0) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_AW;
        end
      end
      ST_AW: if (awready) state_next = ST_W;
      ST_W:  if (wready && wlast) state_next = ST_B;
      ST_B: begin
        if (bvalid) begin
          if (resp_ok(bresp)) begin
            rem_next     = rem - CountWidth'(beats);
            addr_next    = addr + AddrWidth'({beats, 3'b000});
            written_next = written + 24'(beats);
            state_next   = (rem_next == '0) ? ST_DONE : ST_AW;
          end else begin
            done_status = STATUS_BRESP_ERR;
            state_next  = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= ST_IDLE;
      rem                <= '0;
      addr               <= '0;
      written            <= '0;
      beats              <= '0;
      beat_cnt           <= '0;
      ap_idle            <= 1'b1;
      ap_done            <= 1'b0;
      ap_ready           <= 1'b0;
      tracer_return_code <= '0;
      awaddr             <= '0;
      awlen              <= '0;
      awvalid            <= 1'b0;
      wvalid             <= 1'b0;
      wlast              <= 1'b0;
      bready             <= 1'b0;
    end else begin
      state    <= state_next;
      rem      <= rem_next;
      addr     <= addr_next;
      written  <= written_next;
      ap_idle  <= (state_next == ST_IDLE);
      ap_done  <= (state_next == ST_DONE);
      ap_ready <= (state_next == ST_DONE);
      awvalid  <= (state_next == ST_AW);
      wvalid   <= (state_next == ST_W);
      bready   <= (state_next == ST_B);
      if (state_next == ST_AW && state != ST_AW) begin
        awaddr <= addr_next;
        awlen  <= 8'(plan_beats - 9'd1);
        beats  <= plan_beats;
      end
      // wlast is looked ahead one beat so it is valid in the same cycle as the final beat.
      if (state_next == ST_W && state != ST_W) begin
        beat_cnt <= '0;
        wlast    <= (beats == 9'd1);
      end else if (state == ST_W && wready) begin
        beat_cnt <= beat_cnt + 9'd1;
        wlast    <= (beat_cnt + 9'd2 == beats);
      end
      if (state_next == ST_DONE && state != ST_DONE)
        tracer_return_code <= {written_next, done_status};
    end
  end

  assign buf_pop = wvalid & wready;
  assign wdata   = buf_data;
  assign awsize  = SIZE_8B;
  assign awburst = BURST_INCR;
  assign wstrb   = '1;

endmodule

// File: tb/tb_trace_dump_ctrl.sv
// Self-checking bench for trace_dump_ctrl: buffer/slave environment plus a burst-level model.
module tb_trace_dump_ctrl;

  localparam int unsigned MAXB = 16;

  logic        clk = 1'b0, reset = 1'b0, ap_start = 1'b0;
  logic        ap_done, ap_ready, ap_idle, buf_pop;
  logic [63:0] trace_dump = '0, buf_data = '0;
  logic [31:0] tracer_return_code;
  logic [15:0] buf_count = '0;
  logic [63:0] awaddr, wdata;
  logic [7:0]  awlen, wstrb;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp = '0;
  logic        awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b0, bvalid = 1'b0, bready;

  trace_dump_ctrl #(.AddrWidth(64), .MaxBurst(MAXB), .CountWidth(16)) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_done(ap_done), .ap_ready(ap_ready),
    .ap_idle(ap_idle), .trace_dump(trace_dump), .tracer_return_code(tracer_return_code),
    .buf_count(buf_count), .buf_data(buf_data), .buf_pop(buf_pop),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  logic [63:0] fifo[$];
  logic [71:0] aw_q[$], aw_log[$];
  logic [63:0] exp_data[$];
  logic [31:0] exp_ret[$];

  int          tests = 0, fails = 0;
  int unsigned done_cnt = 0, pop_cnt = 0, b_idx = 0, beat = 0, exp_len = 0;
  int          err_idx = -1;
  logic        stall = 1'b0, b_pend = 1'b0, pop_pend = 1'b0, w_act = 1'b0;
  logic        aw_stall_p = 1'b0, w_stall_p = 1'b0, w_mid_p = 1'b0, done_p = 1'b0, p_wlast = 1'b0;
  logic [63:0] p_awaddr = '0, p_wdata = '0;
  logic [7:0]  p_awlen = '0;
  logic [31:0] p_ret = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event observed, expected none", name);
  endtask

  task automatic refresh_buf();
    buf_count = 16'(fifo.size());
    buf_data  = (fifo.size() != 0) ? fifo[0] : 64'd0;
  endtask

  // Spec-level model: split the snapshot into page-bounded bursts, truncate at the failing burst.
  task automatic expect_run(input logic [63:0] base, input int unsigned ofs,
                            input int unsigned n, input int err);
    logic [63:0] a;
    int unsigned rem, b, room, written, popped;
    int          k;
    logic [7:0]  st;
    a = base; rem = n; written = 0; popped = 0; k = 0; st = 8'd0;
    if (base[2:0] != 3'd0) begin
      exp_ret.push_back(32'd2);
      return;
    end
    while (rem != 0) begin
      room = (4096 - int'(a[11:0])) / 8;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      aw_q.push_back({a, 8'(b - 1)});
      popped += b;
      if (k == err) begin
        st = 8'd1;
        break;
      end
      written += b;
      a += 64'(b) * 64'd8;
      rem -= b;
      k++;
    end
    for (int unsigned i = 0; i < popped; i++) exp_data.push_back(fifo[ofs + i]);
    exp_ret.push_back({written[23:0], st});
  endtask

  task automatic mon();
    logic [71:0] e;
    int unsigned end_off;
    if (aw_stall_p) check("aw_hold", {awvalid, awaddr, awlen}, {1'b1, p_awaddr, p_awlen});
    if (w_stall_p)  check("w_hold", {wvalid, wlast, wdata}, {1'b1, p_wlast, p_wdata});
    if (w_mid_p)    check("w_no_bubble", wvalid, 1'b1);
    if (wvalid || buf_pop) check("pop_rule", buf_pop, wvalid && wready);
    if (wvalid && wready) begin
      pop_pend = 1'b1;
      pop_cnt++;
      if (!w_act || exp_data.size() == 0) fail_now("w_unexpected");
      else begin
        check("wdata", wdata, exp_data.pop_front());
        check("wlast", wlast, beat == exp_len);
        check("wstrb", wstrb, 8'hFF);
        if (beat == exp_len) begin
          w_act  = 1'b0;
          b_pend = 1'b1;
        end else beat++;
      end
    end
    if (awvalid && awready) begin
      aw_log.push_back({awaddr, awlen});
      exp_len = awlen;
      if (aw_q.size() == 0 || w_act || b_pend) fail_now("aw_unexpected");
      else begin
        e = aw_q.pop_front();
        check("aw_addr_len", {awaddr, awlen}, e);
        exp_len = int'(e[7:0]);
      end
      check("aw_size_burst", {awsize, awburst}, {3'd3, 2'd1});
      end_off = int'(awaddr[11:0]) + (int'(awlen) + 1) * 8;
      check("aw_4k", end_off <= 4096, 1'b1);
      w_act = 1'b1;
      beat  = 0;
    end
    if (bvalid && bready) begin
      b_pend = 1'b0;
      b_idx++;
    end
    if (ap_done) begin
      done_cnt++;
      check("ap_ready", ap_ready, 1'b1);
      if (exp_ret.size() == 0) fail_now("done_unexpected");
      else check("return_code", tracer_return_code, exp_ret.pop_front());
      if (done_p) fail_now("done_width");
    end else if (tracer_return_code !== p_ret) fail_now("ret_stable");
    aw_stall_p = awvalid && !awready;
    p_awaddr   = awaddr;
    p_awlen    = awlen;
    w_stall_p  = wvalid && !wready;
    p_wlast    = wlast;
    p_wdata    = wdata;
    w_mid_p    = wvalid && wready && !wlast;
    done_p     = ap_done;
    p_ret      = tracer_return_code;
  endtask

  // Environment: trace buffer pops after the edge, slave responses driven at the falling edge.
  initial begin
    logic [63:0] tmp;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend) begin
        if (fifo.size() != 0) tmp = fifo.pop_front();
        pop_pend = 1'b0;
      end
      refresh_buf();
      @(negedge clk);
      if (stall) begin
        awready = ($urandom_range(0, 2) != 0);
        wready  = ($urandom_range(0, 2) != 0);
        bvalid  = b_pend && ($urandom_range(0, 1) == 1);
      end else begin
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = b_pend;
      end
      bresp = (int'(b_idx) == err_idx) ? 2'b10 : (stall ? 2'($urandom_range(0, 1)) : 2'b00);
      #1;
      mon();
    end
  end

  task automatic load(input int unsigned n, input logic [31:0] tag);
    fifo.delete();
    for (int unsigned i = 0; i < n; i++) fifo.push_back({tag, i});
    refresh_buf();
  endtask

  task automatic wait_done(input int unsigned runs, input bit hold, output int unsigned lat);
    int unsigned d0;
    d0 = done_cnt;
    lat = 0;
    while (done_cnt < d0 + runs && lat < 3000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #2;
      if (!hold) ap_start = 1'b0;
    end
    ap_start = 1'b0;
    if (done_cnt < d0 + runs) fail_now("timeout_ap_done");
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic check_aw(input string name, input int unsigned idx, input logic [63:0] a,
                          input logic [7:0] l);
    if (aw_log.size() <= idx) fail_now({name, "_missing"});
    else check(name, aw_log[idx], {a, l});
  endtask

  task automatic start_test(input logic [63:0] base, input int unsigned n, input logic [31:0] tag,
                            input int err, output int unsigned a0, output int unsigned p0);
    trace_dump = base;
    err_idx = err;
    b_idx = 0;
    load(n, tag);
    expect_run(base, 0, n, err);
    a0 = aw_log.size();
    p0 = pop_cnt;
    ap_start = 1'b1;
  endtask

  task automatic check_drained(input string name);
    check(name, {32'(aw_q.size()), 32'(exp_data.size()), 32'(exp_ret.size())}, '0);
  endtask

  initial begin
    int unsigned lat, a0, p0, ofs, n;
    refresh_buf();
    repeat (3) @(negedge clk);
    check("rst_status", {ap_idle, ap_done, ap_ready}, 3'b100);
    check("rst_axi", {awvalid, wvalid, wlast, bready, buf_pop}, 5'b0);
    check("rst_regs", {tracer_return_code, awaddr, awlen}, '0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;

    start_test(64'h1000, 40, 32'h11, -1, a0, p0);
    wait_done(1, 0, lat);
    check_aw("t1_aw0", a0, 64'h1000, 8'd15);
    check_aw("t1_aw1", a0 + 1, 64'h1080, 8'd15);
    check_aw("t1_aw2", a0 + 2, 64'h1100, 8'd7);
    check("t1_aw_count", aw_log.size() - a0, 3);
    check("t1_pops", pop_cnt - p0, 40);
    check("t1_ret", tracer_return_code, 32'h0000_2800);
    check_drained("t1_drained");

    start_test(64'h2000, 1, 32'h22, -1, a0, p0);
    wait_done(1, 0, lat);
    check("t2_latency", lat, 5);
    check("t2_ret", tracer_return_code, 32'h0000_0100);

    start_test(64'h1FC0, 20, 32'h33, -1, a0, p0);
    wait_done(1, 0, lat);
    check_aw("t3_aw0", a0, 64'h1FC0, 8'd7);
    check_aw("t3_aw1", a0 + 1, 64'h2000, 8'd11);
    check("t3_pops", pop_cnt - p0, 20);
    check("t3_ret", tracer_return_code, 32'h0000_1400);

    start_test(64'h3000, 0, 32'h44, -1, a0, p0);
    wait_done(1, 0, lat);
    check("t4_latency", lat, 2);
    check("t4_aw_count", aw_log.size() - a0, 0);
    check("t4_ret", tracer_return_code, 32'h0);

    start_test(64'h1004, 5, 32'h55, -1, a0, p0);
    wait_done(1, 0, lat);
    check("t5_latency", lat, 2);
    check("t5_aw_count", aw_log.size() - a0, 0);
    check("t5_pops", pop_cnt - p0, 0);
    check("t5_buf_left", fifo.size(), 5);
    check("t5_ret", tracer_return_code, 32'h0000_0002);

    start_test(64'h4000, 40, 32'h66, 1, a0, p0);
    wait_done(1, 0, lat);
    repeat (10) @(negedge clk);
    #2;
    check("t6_aw_count", aw_log.size() - a0, 2);
    check("t6_pops", pop_cnt - p0, 32);
    check("t6_buf_left", fifo.size(), 8);
    check("t6_ret", tracer_return_code, 32'h0000_1001);
    check_drained("t6_drained");

    // Stalling slave, ap_start held: entries appended mid-run belong to the second run.
    stall = 1'b1;
    start_test(64'h0FE0, 20, 32'h77, -1, a0, p0);
    n = 0;
    while (aw_log.size() == a0 && n < 500) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (aw_log.size() == a0) fail_now("t7_timeout_first_aw");
    ofs = fifo.size();
    for (int unsigned i = 0; i < 5; i++) fifo.push_back({32'h88, i});
    refresh_buf();
    expect_run(64'h0FE0, ofs, 5, -1);
    wait_done(2, 1, lat);
    check_aw("t7_aw0", a0, 64'h0FE0, 8'd3);
    check_aw("t7_aw1", a0 + 1, 64'h1000, 8'd15);
    check_aw("t7_aw2", a0 + 2, 64'h0FE0, 8'd3);
    check_aw("t7_aw3", a0 + 3, 64'h1000, 8'd0);
    check("t7_pops", pop_cnt - p0, 25);
    check("t7_ret", tracer_return_code, 32'h0000_0500);
    check("t7_idle", ap_idle, 1'b1);
    check_drained("t7_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
